pe_skew_feeder: RTL and testbench
=================================

Name: pe_skew_feeder

Overview:
- Edge feeder and transmitter for the PE array. It drives the x_i/wc_i operand lanes that the PEs consume.
- Accepts one operand slice per beat, one MUL_BW element per lane, over a valid/ready handshake.
- Emits the slices diagonally skewed: lane r is delayed r extra cycles, so operands meet correctly in the systolic array.
- Latches the gemm_uno mode per frame and flushes the skew pipeline before accepting the next frame.

Parameters:
- LANES, 4, number of array rows/columns fed; must be >= 1.
- MUL_BW, 16, operand width, signed fixed-point, matching the PE multiplier input.
- LEN_BW, 16, width of the frame-length counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- mode_i  in  2  gemm_uno for the frame (00 gemm, 01 div, 10 exp, 11 log); sampled on the first beat of a frame
- in_valid  in  1  slice valid
- in_ready  out  1  feeder can accept a slice
- in_data  in  LANES*MUL_BW  slice; lane r = bits [r*MUL_BW +: MUL_BW]
- in_last  in  1  slice is the final beat of the frame
- lane_o  out  LANES*MUL_BW  skewed operands to the array edge
- lane_vld_o  out  LANES  per-lane data-valid
- mode_o  out  2  latched gemm_uno, driven to every PE
- busy_o  out  1  frame in progress (not IDLE)
- done_o  out  1  one-cycle pulse when the last beat exits lane LANES-1
- frame_len_o  out  LEN_BW  beats accepted in the most recent completed frame

Behaviour:
- Reset values: all outputs 0, except in_ready = 1 (combinational from IDLE). State is IDLE; all delay lines are cleared.
- Accept = in_valid & in_ready.
- Skew pipeline:
  - Lane r is a chain of r+1 registers carrying {data, vld}; lane LANES-1 also carries a last flag.
  - The chain shifts every cycle unconditionally; there is no output backpressure.
  - Stage 0 loads in_data[r] with vld = 1 on accept. Otherwise it loads data 0, vld 0 (a bubble).
  - A zero bubble is harmless to the PE accumulate path.
  - Latency: a slice accepted at edge t appears on lane r after edge t+r.
- FSM:
  - IDLE: in_ready = 1.
    - Accept: latch mode_o <= mode_i and set len = 1.
    - If in_last, go to FLUSH (or stay in IDLE if LANES == 1); otherwise go to STREAM.
  - STREAM: in_ready = 1.
    - Each accept increments len; the counter saturates at all-ones.
    - Accept with in_last goes to FLUSH and loads flush_cnt = LANES-1.
    - in_valid low inserts a bubble and stays in STREAM.
  - FLUSH: in_ready = 0.
    - flush_cnt decrements each cycle; at 1 it goes to IDLE.
    - With LANES == 1, the FSM goes from STREAM straight to IDLE and FLUSH is skipped.
- busy_o = (state != IDLE). mode_o changes only on the first accept of a frame. mode_i is ignored at all other times.
- done_o:
  - Equals the last flag at the lane LANES-1 output.
  - Asserts in the same cycle in_ready returns to 1, so a back-to-back frame is legal.
  - The new frame's lane-0 data and the new mode_o update on the same edge.
- frame_len_o updates when done_o asserts and holds until the next done_o.
- Simultaneous events: in the done_o cycle, an accept of a new first beat is allowed. Old lane LANES-1 data is consumed under the old mode_o.
- rst_n assertion mid-frame: the frame is aborted, pipelines cleared, no done_o.

Optional Feature:
- Macro: PE_SKEW_FEEDER_PERF_EN.
- Defined:
  - Adds output bubble_cnt_o, LEN_BW wide. It counts STREAM cycles with in_valid = 0 in the current frame.
  - The count clears on the first accept of a frame and saturates at all-ones.
  - It is frozen and readable after done_o.
- Undefined: the port and counter are absent. Functional behaviour is otherwise identical.

Decomposition:
- Shared package pe_pkg:
  - gemm_uno_e enum (GEMM = 2'b00, DIV, EXP, LOG).
  - feeder_state_e (IDLE, STREAM, FLUSH).
  - Default MUL_BW.
- One sub-module, skew_delay_line: parameterised depth and width; a shift register with async reset. It is instantiated per lane with depth r+1.

Test Plan:
- LANES = 4, mode_i = 00, frame of 3 beats with lane values {1,2,3,4}, {5,6,7,8}, {9,10,11,12} and valid held high:
  - lane0 shows 1, 5, 9 on cycles t+0..2; lane3 shows 4, 8, 12 on t+3..5.
  - done_o pulses on t+5; frame_len_o = 3.
- Bubble: in_valid low for 2 cycles mid-frame:
  - Zeros with lane_vld_o = 0 propagate diagonally; done_o is delayed by 2.
  - With PERF_EN, bubble_cnt_o = 2.
- Flush and back-to-back:
  - in_ready is 0 for exactly 3 cycles after the last beat.
  - A second frame with mode_i = 10 is accepted in the done_o cycle; mode_o changes to 10 on that edge.
- mode_i toggled mid-frame: mode_o holds the first-beat value.
- Single-beat frame, in_last on the first beat: in_ready stays low for LANES-1 cycles, then done_o fires; frame_len_o = 1.
- rst_n pulsed during FLUSH: all outputs clear immediately; no done_o; in_ready = 1 after release.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types for the PE array edge logic: operation mode, feeder FSM states
// and the default operand width.
package pe_pkg;

  localparam int PE_MUL_BW = 16;

  typedef enum logic [1:0] {
    GEMM = 2'b00,
    DIV  = 2'b01,
    EXP  = 2'b10,
    LOG  = 2'b11
  } gemm_uno_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    STREAM = 2'b01,
    FLUSH  = 2'b10
  } feeder_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register with asynchronous clear; one instance per lane
// gives that lane its diagonal skew.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][WIDTH-1:0] sr_q;

  if (DEPTH == 1) begin : g_single
    // Single stage: the lane register itself.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sr_q <= '0;
      end else begin
        sr_q[0] <= d_i;
      end
    end
  end else begin : g_chain
    // Unconditional shift; the array edge applies no backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sr_q <= '0;
      end else begin
        sr_q <= {sr_q[DEPTH-2:0], d_i};
      end
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/pe_skew_feeder.sv
// Skewed operand feeder for the PE array edge: lane r trails lane 0 by r cycles.
// Optional PE_SKEW_FEEDER_PERF_EN adds a per-frame input bubble counter.
module pe_skew_feeder
  import pe_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int MUL_BW = PE_MUL_BW,
  parameter int LEN_BW = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              mode_i,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*MUL_BW-1:0] in_data,
  input  logic                    in_last,
  output logic [LANES*MUL_BW-1:0] lane_o,
  output logic [LANES-1:0]        lane_vld_o,
  output logic [1:0]              mode_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [LEN_BW-1:0]       frame_len_o
`ifdef PE_SKEW_FEEDER_PERF_EN
  ,
  output logic [LEN_BW-1:0]       bubble_cnt_o
`endif
);

  localparam int CNT_BW = $clog2(LANES + 1);
  localparam logic [CNT_BW-1:0] FLUSH_LOAD = CNT_BW'(LANES - 1);

  feeder_state_e     state_q, state_d;
  logic [CNT_BW-1:0] flush_cnt_q, flush_cnt_d;
  logic [LEN_BW-1:0] len_q, len_d;
  logic [LEN_BW-1:0] frame_len_q, frame_len_d;
  gemm_uno_e         mode_q, mode_d;
  logic              accept_s;
  logic              frame_end_s;

  assign in_ready = (state_q != FLUSH);
  assign accept_s = in_valid & in_ready;

  // Frame FSM: mode latch, beat counting and the flush countdown.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    len_d       = len_q;
    mode_d      = mode_q;
    frame_end_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          mode_d = gemm_uno_e'(mode_i);
          len_d  = LEN_BW'(1);
          if (!in_last) begin
            state_d = STREAM;
          end else if (LANES == 1) begin
            frame_end_s = 1'b1;
          end else begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (accept_s) begin
          len_d = (len_q == '1) ? len_q : len_q + LEN_BW'(1);
          if (in_last && (LANES == 1)) begin
            state_d     = IDLE;
            frame_end_s = 1'b1;
          end else if (in_last) begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_LOAD;
          end else begin
            state_d = STREAM;
          end
        end else begin
          state_d = STREAM;
        end
      end
      FLUSH: begin
        // Leaving FLUSH coincides with the last beat reaching the final lane.
        if (flush_cnt_q == CNT_BW'(1)) begin
          state_d     = IDLE;
          frame_end_s = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q - CNT_BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign frame_len_d = frame_end_s ? len_d : frame_len_q;

  // Control and frame-status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      len_q       <= '0;
      frame_len_q <= '0;
      mode_q      <= GEMM;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      len_q       <= len_d;
      frame_len_q <= frame_len_d;
      mode_q      <= mode_d;
    end
  end

  assign mode_o      = mode_q;
  assign busy_o      = (state_q != IDLE);
  assign frame_len_o = frame_len_q;

  for (genvar r = 0; r < LANES; r++) begin : g_lane
    logic [MUL_BW-1:0] din_s;
    // Non-accepted cycles inject a zero bubble.
    assign din_s = accept_s ? in_data[r*MUL_BW +: MUL_BW] : '0;

    if (r == LANES - 1) begin : g_tail
      logic [MUL_BW+1:0] q_s;
      skew_delay_line #(.DEPTH(r + 1), .WIDTH(MUL_BW + 2)) u_dl (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   ({accept_s & in_last, accept_s, din_s}),
        .q_o   (q_s)
      );
      assign lane_o[r*MUL_BW +: MUL_BW] = q_s[MUL_BW-1:0];
      assign lane_vld_o[r]              = q_s[MUL_BW];
      assign done_o                     = q_s[MUL_BW+1];
    end else begin : g_body
      logic [MUL_BW:0] q_s;
      skew_delay_line #(.DEPTH(r + 1), .WIDTH(MUL_BW + 1)) u_dl (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   ({accept_s, din_s}),
        .q_o   (q_s)
      );
      assign lane_o[r*MUL_BW +: MUL_BW] = q_s[MUL_BW-1:0];
      assign lane_vld_o[r]              = q_s[MUL_BW];
    end
  end

`ifdef PE_SKEW_FEEDER_PERF_EN
  logic [LEN_BW-1:0] bub_q, bub_d;

  // Bubble count: cleared by a frame's first beat, frozen outside STREAM.
  always_comb begin
    bub_d = bub_q;
    if ((state_q == IDLE) && accept_s) begin
      bub_d = '0;
    end else if ((state_q == STREAM) && !in_valid && (bub_q != '1)) begin
      bub_d = bub_q + LEN_BW'(1);
    end else begin
      bub_d = bub_q;
    end
  end

  // Bubble counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bub_q <= '0;
    end else begin
      bub_q <= bub_d;
    end
  end

  assign bubble_cnt_o = bub_q;
`endif

endmodule

// File: tb/tb_pe_skew_feeder.sv
// Scoreboard bench for pe_skew_feeder: the driver queues expected lane beats and
// frame completions, a negedge monitor checks them as the DUT presents them.
module tb_pe_skew_feeder;

  localparam int LANES  = 4;
  localparam int MUL_BW = 16;
  localparam int LEN_BW = 16;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [1:0]              mode_i;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*MUL_BW-1:0] in_data;
  logic                    in_last;
  logic [LANES*MUL_BW-1:0] lane_o;
  logic [LANES-1:0]        lane_vld_o;
  logic [1:0]              mode_o;
  logic                    busy_o;
  logic                    done_o;
  logic [LEN_BW-1:0]       frame_len_o;
`ifdef PE_SKEW_FEEDER_PERF_EN
  logic [LEN_BW-1:0]       bubble_cnt_o;
`endif

  pe_skew_feeder #(.LANES(LANES), .MUL_BW(MUL_BW), .LEN_BW(LEN_BW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_i      (mode_i),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .lane_o      (lane_o),
    .lane_vld_o  (lane_vld_o),
    .mode_o      (mode_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .frame_len_o (frame_len_o)
`ifdef PE_SKEW_FEEDER_PERF_EN
    ,
    .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] d; int e; } lexp_t;
  typedef struct { logic [15:0] len; logic [1:0] mode; logic [15:0] bub; int e; } dexp_t;

  lexp_t      lane_q [LANES][$];
  dexp_t      done_q [$];
  int         total = 0;
  int         bad = 0;
  int         edge_cnt = 0;
  logic [1:0] frame_mode = 2'b00;
  int         f_len = 0;
  int         f_bub = 0;
  bit         streaming = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", nm, act, exp, edge_cnt);
    end
  endfunction

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: every presented lane beat and done pulse must match the head of its queue.
  always @(negedge clk) begin : mon
    lexp_t lx;
    dexp_t dx;
    if (rst_n) begin
      for (int r = 0; r < LANES; r++) begin
        if (lane_vld_o[r]) begin
          if (lane_q[r].size() == 0) begin
            total++;
            bad++;
            $display("FAIL lane%0d_unexpected: got vld=1 data=0x%0h expected no beat", r,
                     lane_o[r*MUL_BW +: MUL_BW]);
          end else begin
            lx = lane_q[r].pop_front();
            chk($sformatf("lane%0d_data", r), 32'(lane_o[r*MUL_BW +: MUL_BW]), 32'(lx.d));
            chk($sformatf("lane%0d_edge", r), 32'(edge_cnt), 32'(lx.e));
          end
        end else begin
          chk($sformatf("lane%0d_bubble_zero", r), 32'(lane_o[r*MUL_BW +: MUL_BW]), 32'd0);
        end
      end
      if (done_o) begin
        if (done_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_unexpected: got done=1 expected 0 (edge %0d)", edge_cnt);
        end else begin
          dx = done_q.pop_front();
          chk("done_edge", 32'(edge_cnt), 32'(dx.e));
          chk("frame_len", 32'(frame_len_o), 32'(dx.len));
          chk("done_mode", 32'(mode_o), 32'(dx.mode));
`ifdef PE_SKEW_FEEDER_PERF_EN
          chk("bubble_cnt", 32'(bubble_cnt_o), 32'(dx.bub));
`endif
        end
      end
    end
  end

  // One beat, driven from a negedge; expectations are queued for the coming edge.
  task automatic send(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                      input logic [15:0] d3, input logic [1:0] md, input bit first, input bit last);
    logic [15:0] dv [LANES];
    dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
    in_valid = 1'b1;
    in_data  = {d3, d2, d1, d0};
    in_last  = last;
    mode_i   = md;
    chk("ready_on_send", 32'(in_ready), 32'd1);
    if (first) begin
      frame_mode = md;
      f_len = 0;
      f_bub = 0;
    end
    f_len++;
    for (int r = 0; r < LANES; r++) lane_q[r].push_back('{dv[r], edge_cnt + 1 + r});
    if (last) begin
      done_q.push_back('{16'(f_len), frame_mode, 16'(f_bub), edge_cnt + LANES});
      streaming = 1'b0;
    end else begin
      streaming = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("mode_latched", 32'(mode_o), 32'(frame_mode));
    chk("busy_in_frame", 32'(busy_o), 32'd1);
    @(negedge clk);
  endtask

  // One cycle with in_valid low; mode_i is scrambled to show it is ignored.
  task automatic idle(input bit exp_ready);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    mode_i   = ~mode_i;
    chk("ready_idle", 32'(in_ready), 32'(exp_ready));
    if (streaming) f_bub++;
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    mode_i   = 2'b00;
    @(negedge clk);
    chk("rst_lane_o", 32'(lane_o == '0), 32'd1);
    chk("rst_lane_vld", 32'(lane_vld_o), 32'd0);
    chk("rst_mode", 32'(mode_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_frame_len", 32'(frame_len_o), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Three back-to-back beats, then exactly three flush cycles.
    send(16'd1, 16'd2, 16'd3, 16'd4, 2'b00, 1'b1, 1'b0);
    send(16'd5, 16'd6, 16'd7, 16'd8, 2'b00, 1'b0, 1'b0);
    send(16'd9, 16'd10, 16'd11, 16'd12, 2'b00, 1'b0, 1'b1);
    idle(1'b0); idle(1'b0); idle(1'b0);

    // Accepted in the done cycle of the previous frame; mode_i toggles mid-frame; two bubbles.
    send(16'h0011, 16'h0022, 16'h0033, 16'h0044, 2'b10, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1);
    send(16'h0055, 16'h0066, 16'h0077, 16'h0088, 2'b01, 1'b0, 1'b0);
    send(16'h0099, 16'h00AA, 16'h00BB, 16'h00CC, 2'b11, 1'b0, 1'b1);
    idle(1'b0); idle(1'b0); idle(1'b0); idle(1'b1);

    // Single-beat frame with signed extremes.
    send(16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 2'b01, 1'b1, 1'b1);
    idle(1'b0); idle(1'b0); idle(1'b0); idle(1'b1); idle(1'b1);

    // Reset asserted while flushing: everything clears, no done.
    send(16'h1234, 16'h2345, 16'h3456, 16'h4567, 2'b11, 1'b1, 1'b0);
    send(16'h5678, 16'h6789, 16'h789A, 16'h89AB, 2'b11, 1'b0, 1'b1);
    idle(1'b0);
    #2;
    rst_n = 1'b0;
    for (int r = 0; r < LANES; r++) lane_q[r].delete();
    done_q.delete();
    streaming = 1'b0;
    #1;
    chk("abort_lane_o", 32'(lane_o == '0), 32'd1);
    chk("abort_lane_vld", 32'(lane_vld_o), 32'd0);
    chk("abort_mode", 32'(mode_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_frame_len", 32'(frame_len_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) idle(1'b1);

    // Recovery frame.
    send(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 2'b00, 1'b1, 1'b0);
    send(16'h0E0E, 16'h0F0F, 16'h1010, 16'h1111, 2'b10, 1'b0, 1'b1);
    idle(1'b0); idle(1'b0); idle(1'b0); idle(1'b1);

    for (int i = 0; i < 20; i++) begin
      if (done_q.size() != 0 || lane_q[LANES-1].size() != 0) @(negedge clk);
    end
    for (int r = 0; r < LANES; r++) chk($sformatf("lane%0d_queue_drained", r), 32'(lane_q[r].size()), 32'd0);
    chk("done_queue_drained", 32'(done_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
